ghostbus_arbiter: RTL and testbench
===================================

// Module: ghostbus_arbiter
// PURPOSE
//  Round-robin master arbiter sharing one ghostbus (24b addr / 32b data, wen/rstb strobes) between N_REQ requesters.
//  Examples of requesters: host bridge, local sequencer, scrubber.
//  Sits above the top-level ghostbus driver ports and drives gb_addr/gb_wdata/gb_wen/gb_rstb; samples gb_rdata.
//  Serialises single-beat read/write transactions and holds the address for the fixed bus read latency.
// PARAMETERS
//  N_REQ   2   number of requesters, 1..8
//  AW      24  bus address width
//  DW      32  bus data width
//  RD_LAT  2   cycles from read strobe to valid gb_rdata, >=1
// PORTS
//  gb_clk     in   1         single clock; all logic on posedge
//  gb_rst     in   1         synchronous, active-high reset
//  req_valid  in   N_REQ     request pending; held until matching req_done
//  req_we     in   N_REQ     1=write, 0=read
//  req_addr   in   N_REQ*AW  packed, requester i at [(i+1)*AW-1 -: AW]
//  req_wdata  in   N_REQ*DW  packed as req_addr
//  req_done   out  N_REQ     one-cycle completion pulse, one-hot
//  req_rdata  out  DW        read data, valid while req_done of the reader is high
//  gb_addr    out  AW        bus address
//  gb_wdata   out  DW        bus write data
//  gb_wen     out  1         write strobe
//  gb_rstb    out  1         read strobe
//  gb_rdata   in   DW        bus read data
//  busy       out  1         state != IDLE
//  grant_id   out  IW        index of current or last granted requester; IW = max(1,$clog2(N_REQ))
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; rr pointer 0.
//  - Reset mid-transaction aborts it: no req_done, strobes low on the next cycle.
//  - Outputs are registered; there is no combinational path from req_* to gb_*.
//  - FSM:
//    - IDLE -> ISSUE: on any eligible req_valid. Eligible = req_valid & ~req_done, which masks the requester just served.
//    - ISSUE lasts 1 cycle. gb_addr/gb_wdata are loaded from the winner. gb_wen=we; gb_rstb=~we. Exactly one strobe is high, for exactly that cycle.
//    - ISSUE -> RESP if we.
//    - ISSUE -> WAIT if ~we, with cnt=RD_LAT-1. If RD_LAT==1, ISSUE -> RESP directly.
//    - WAIT: gb_addr held, strobes low. Decrement cnt; -> RESP when cnt==0.
//    - RESP: for reads, gb_rdata was captured at the edge entering RESP. req_done[grant]=1 for this cycle. -> IDLE.
//  - Latency: req_valid seen at edge T gives ISSUE in cycle T.
//    - Write: req_done in cycle T+1.
//    - Read: gb_rdata is sampled at edge T+RD_LAT; req_done in cycle T+RD_LAT.
//  - Throughput: IDLE always separates transactions. Minimum spacing: write every 3 cycles, read every RD_LAT+2.
//  - Arbitration: round-robin starting at ptr. After grant to i, ptr = (i+1) mod N_REQ. A lone requester wins every time.
//  - Simultaneous requests: lowest index at or after ptr wins. Losers keep req_valid high and are never dropped.
//  - gb_addr/gb_wdata keep their last value when not in ISSUE/WAIT; only the strobes qualify the bus.
//  - Requester contract:
//    - Changing req_addr/req_wdata/req_we while valid and not yet done is a protocol violation; the transaction uses the values latched in ISSUE.
//    - After req_done the requester drops valid or presents a new request in the next cycle.
//  - req_rdata holds its value until the next read completes. Writes leave req_rdata unchanged.
// STRUCTURE
//  - Shared include ghostbus_arb_defs.vh: FSM state encodings (IDLE/ISSUE/WAIT/RESP, 2b) and the IW width macro.
//  - Sub-module gb_rr_pick: combinational round-robin picker, inputs eligible[N_REQ] and ptr, outputs one-hot grant and index.
//  - Top level: FSM, latency counter, bus/result registers.
// TESTING
//  - Reset: gb_rst high 3 cycles with req_valid=2'b11. All outputs stay 0; the first ISSUE happens 1 cycle after reset drops.
//  - Single write: req0 addr=0x000001, wdata=0x5A, we=1.
//    - Expect gb_wen=1 for exactly 1 cycle with gb_addr=0x000001 and gb_wdata=0x5A.
//    - Expect req_done=2'b01 in the next cycle.
//  - Single read, RD_LAT=2: req1 addr=0x000080 with model gb_rdata=0x1234.
//    - Expect gb_rstb for 1 cycle and gb_addr held 2 cycles.
//    - Expect req_done=2'b10 with req_rdata=0x1234.
//  - Contention: both valid from reset, 4 transactions each.
//    - Expect grants to alternate 0,1,0,1...; no starvation; done pulses one-hot.
//  - Back-to-back lone requester: req0 issues 3 writes, presenting each new request the cycle after done.
//    - Expect ISSUE spacing of 3 cycles and no duplicate strobe.
//  - Reset mid-read: assert gb_rst in the WAIT cycle.
//    - Expect no req_done; busy=0 and all strobes 0 the cycle after; ptr=0.

Source files
------------

// File: rtl/ghostbus_arbiter_pkg.sv
// Shared definitions for the ghostbus round-robin arbiter: FSM encodings and
// the grant-index width helper.
package ghostbus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Grant index width; a single requester still gets a 1-bit index.
    function automatic int calc_iw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ghostbus_arbiter_if.sv
// Requester handshake and ghostbus signals shared between the arbiter and the
// agents around it.
interface ghostbus_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int AW    = 24,
    parameter int DW    = 32
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_we;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_wdata;
    logic [N_REQ-1:0]    req_done;
    logic [DW-1:0]       req_rdata;
    logic [AW-1:0]       gb_addr;
    logic [DW-1:0]       gb_wdata;
    logic                gb_wen;
    logic                gb_rstb;
    logic [DW-1:0]       gb_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, gb_rdata,
        output req_done, req_rdata, gb_addr, gb_wdata, gb_wen, gb_rstb
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, gb_rdata,
        input  req_done, req_rdata, gb_addr, gb_wdata, gb_wen, gb_rstb
    );
endinterface

// File: rtl/ghostbus_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr,
// returned both one-hot and as an index.
module gb_rr_pick #(
    parameter int N_REQ = 2,
    parameter int IW    = 1
) (
    input  logic [N_REQ-1:0] i_eligible,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);

    logic [IW-1:0] w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_j = IW'((32'(i_ptr) + k) % N_REQ);
            if (!o_any && i_eligible[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
            end
        end
    end

endmodule

// File: rtl/ghostbus_arbiter.sv
// Round-robin arbiter serialising single-beat read/write transactions from
// N_REQ requesters onto one ghostbus with a fixed read latency.
module ghostbus_arbiter
    import ghostbus_arbiter_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int RD_LAT = 2,
    localparam int IW    = calc_iw(N_REQ)
) (
    input  logic                gb_clk,
    input  logic                gb_rst,
    ghostbus_arbiter_if.master  bus,
    output logic                busy,
    output logic [IW-1:0]       grant_id
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    logic [1:0]       r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_gid;
    logic             r_we;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic             r_wen;
    logic             r_rstb;
    logic [N_REQ-1:0] r_done;
    logic [DW-1:0]    r_rdata;

    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_idx;
    logic             w_any;
    logic             w_sel_we;
    logic [AW-1:0]    w_sel_addr;
    logic [DW-1:0]    w_sel_wdata;

    // Masking with req_done keeps the requester just served out of the race.
    assign w_elig = bus.req_valid & ~r_done;

    gb_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .i_eligible (w_elig),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_idx      (w_idx),
        .o_any      (w_any)
    );

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_we    = bus.req_we[i];
                w_sel_addr  = bus.req_addr[i*AW +: AW];
                w_sel_wdata = bus.req_wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_rstb  <= 1'b0;
            r_done  <= '0;
            r_rdata <= '0;
        end else begin
            r_wen  <= 1'b0;
            r_rstb <= 1'b0;
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_ISSUE;
                        r_gid   <= w_idx;
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_wen   <= w_sel_we;
                        r_rstb  <= ~w_sel_we;
                        r_ptr   <= (32'(w_idx) == N_REQ - 1) ? '0 : w_idx + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (r_we || RD_LAT == 1) begin
                        r_state       <= ST_RESP;
                        r_done[r_gid] <= 1'b1;
                        if (!r_we) r_rdata <= bus.gb_rdata;
                    end else begin
                        r_state <= ST_WAIT;
                        r_cnt   <= CW'(RD_LAT - 1);
                    end
                end
                ST_WAIT: begin
                    // Leave on the edge where the decremented count reaches zero,
                    // which is edge ISSUE+RD_LAT.
                    if (r_cnt <= CW'(1)) begin
                        r_state       <= ST_RESP;
                        r_done[r_gid] <= 1'b1;
                        r_rdata       <= bus.gb_rdata;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_done  = r_done;
    assign bus.req_rdata = r_rdata;
    assign bus.gb_addr   = r_addr;
    assign bus.gb_wdata  = r_wdata;
    assign bus.gb_wen    = r_wen;
    assign bus.gb_rstb   = r_rstb;
    assign busy          = (r_state != ST_IDLE);
    assign grant_id      = r_gid;

endmodule

// File: tb/tb_ghostbus_arbiter.sv
// Bench for ghostbus_arbiter: transaction-level reference model compared on
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_ghostbus_arbiter;

    localparam int N      = 2;
    localparam int AW     = 24;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;
    localparam int IW     = 1;

    logic          gb_clk = 1'b0;
    logic          gb_rst;
    logic          busy;
    logic [IW-1:0] grant_id;

    ghostbus_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

    ghostbus_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .gb_clk   (gb_clk),
        .gb_rst   (gb_rst),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 gb_clk = ~gb_clk;

    // Requester-side drive values
    bit            t_valid [N];
    bit            t_we    [N];
    logic [AW-1:0] t_addr  [N];
    logic [DW-1:0] t_wdata [N];
    logic [DW-1:0] t_rdata;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign bus.req_valid[g]            = t_valid[g];
        assign bus.req_we[g]               = t_we[g];
        assign bus.req_addr[g*AW +: AW]    = t_addr[g];
        assign bus.req_wdata[g*DW +: DW]   = t_wdata[g];
    end
    assign bus.gb_rdata = t_rdata;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: a transaction occupies cycles k = 0 .. len-1 after its grant,
    // strobe at k=0, done at k=len-1, then one idle cycle.
    bit            m_active;
    bit            m_we;
    int            m_k, m_len, m_win, m_ptr, m_gid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    int            rq_left [N];
    bit            auto_new, b2b, wr_only, rd_fixed;
    logic [DW-1:0] rd_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit done_of(input int i);
        return m_active && (m_k == m_len - 1) && (m_win == i);
    endfunction

    task automatic model_step();
        if (gb_rst) begin
            m_active = 0; m_we = 0; m_k = 0; m_len = 0; m_win = 0; m_ptr = 0; m_gid = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
            return;
        end
        if (m_active) begin
            if (m_k == m_len - 1) m_active = 0;
            else begin
                m_k++;
                if (m_k == m_len - 1 && !m_we) m_rdata = t_rdata;
            end
        end else begin
            for (int s = 0; s < N; s++) begin
                int j = (m_ptr + s) % N;
                if (t_valid[j]) begin
                    m_active = 1; m_k = 0; m_win = j; m_gid = j;
                    m_we = t_we[j]; m_len = t_we[j] ? 2 : RD_LAT + 1;
                    m_addr = t_addr[j]; m_wdata = t_wdata[j];
                    m_ptr = (j + 1) % N;
                    break;
                end
            end
        end
    endtask

    task automatic rand_req(input int i);
        t_valid[i] = 1'b1;
        t_we[i]    = wr_only ? 1'b1 : 1'($urandom_range(1));
        t_addr[i]  = AW'($urandom());
        t_wdata[i] = $urandom();
    endtask

    task automatic sample();
        @(negedge gb_clk);
        cyc++;
        chk("busy",      64'(busy),         64'(m_active));
        chk("gb_wen",    64'(bus.gb_wen),   64'(m_active && m_k == 0 && m_we));
        chk("gb_rstb",   64'(bus.gb_rstb),  64'(m_active && m_k == 0 && !m_we));
        chk("gb_addr",   64'(bus.gb_addr),  64'(m_addr));
        chk("gb_wdata",  64'(bus.gb_wdata), 64'(m_wdata));
        chk("req_done",  64'(bus.req_done),
            (m_active && m_k == m_len - 1) ? 64'(N'(1) << m_win) : 64'(0));
        chk("req_rdata", 64'(bus.req_rdata), 64'(m_rdata));
        chk("grant_id",  64'(grant_id),     64'(m_gid));
    endtask

    // Requesters react to this cycle's completions, then the model takes the edge.
    task automatic advance();
        for (int i = 0; i < N; i++) begin
            if (done_of(i)) begin
                rq_left[i]--;
                if (rq_left[i] > 0 && auto_new && (b2b || $urandom_range(1) == 1)) rand_req(i);
                else t_valid[i] = 1'b0;
            end else if (!t_valid[i] && rq_left[i] > 0 && auto_new && $urandom_range(3) == 0) begin
                rand_req(i);
            end
        end
        t_rdata = rd_fixed ? rd_val : $urandom();
        model_step();
    endtask

    task automatic drain(input string name, input int limit);
        int c = 0;
        while ((rq_left[0] + rq_left[1] > 0 || m_active) && c < limit) begin
            sample();
            advance();
            c++;
        end
        chk(name, 64'(rq_left[0] + rq_left[1] + int'(m_active)), 64'(0));
    endtask

    initial begin
        int g_seq[$];
        int wen_at[$];
        int rstb_cnt;

        gb_rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            t_valid[i] = 0; t_we[i] = 0; t_addr[i] = '0; t_wdata[i] = '0; rq_left[i] = 0;
        end
        auto_new = 1; b2b = 1; wr_only = 0; rd_fixed = 0; rd_val = '0;

        // Reset held 3 cycles with both requesters pending, then contention
        rq_left = '{4, 4};
        rand_req(0);
        rand_req(1);
        advance();
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("rst_busy",    64'(busy), 64'(0));
            chk("rst_strobes", 64'({bus.gb_wen, bus.gb_rstb}), 64'(0));
            chk("rst_done",    64'(bus.req_done), 64'(0));
            if (c == 2) gb_rst = 1'b0;
            advance();
        end
        for (int c = 0; c < 200 && (rq_left[0] + rq_left[1] > 0 || m_active); c++) begin
            sample();
            if (c == 0) begin
                chk("first_issue_busy", 64'(busy), 64'(1));
                chk("first_issue_gid",  64'(grant_id), 64'(0));
                chk("first_issue_strb", 64'(bus.gb_wen | bus.gb_rstb), 64'(1));
            end
            if (bus.gb_wen || bus.gb_rstb) g_seq.push_back(int'(grant_id));
            advance();
        end
        chk("contention_drain", 64'(rq_left[0] + rq_left[1]), 64'(0));
        chk("grant_count", 64'(g_seq.size()), 64'(8));
        foreach (g_seq[k]) chk("grant_order", 64'(g_seq[k]), 64'(k % 2));

        // Single write from requester 0
        auto_new = 0; b2b = 0;
        sample();
        rq_left[0] = 1; t_valid[0] = 1; t_we[0] = 1; t_addr[0] = 24'h000001; t_wdata[0] = 32'h5A;
        advance();
        sample();
        chk("wr_wen",   64'(bus.gb_wen),   64'(1));
        chk("wr_rstb",  64'(bus.gb_rstb),  64'(0));
        chk("wr_addr",  64'(bus.gb_addr),  64'(24'h000001));
        chk("wr_wdata", 64'(bus.gb_wdata), 64'(32'h5A));
        advance();
        sample();
        chk("wr_done",  64'(bus.req_done), 64'(2'b01));
        chk("wr_wen_1", 64'(bus.gb_wen),   64'(0));
        advance();

        // Single read from requester 1 with fixed bus data
        sample();
        rd_fixed = 1; rd_val = 32'h1234;
        rq_left[1] = 1; t_valid[1] = 1; t_we[1] = 0; t_addr[1] = 24'h000080;
        advance();
        sample();
        chk("rd_rstb",   64'(bus.gb_rstb), 64'(1));
        chk("rd_addr0",  64'(bus.gb_addr), 64'(24'h000080));
        advance();
        sample();
        chk("rd_rstb_1", 64'(bus.gb_rstb), 64'(0));
        chk("rd_addr1",  64'(bus.gb_addr), 64'(24'h000080));
        advance();
        sample();
        chk("rd_done",   64'(bus.req_done),  64'(2'b10));
        chk("rd_rdata",  64'(bus.req_rdata), 64'(32'h1234));
        advance();

        // Lone requester, three back-to-back writes
        sample();
        rd_fixed = 0; auto_new = 1; b2b = 1; wr_only = 1;
        rq_left[0] = 3;
        rand_req(0);
        advance();
        rstb_cnt = 0;
        for (int c = 0; c < 40 && (rq_left[0] > 0 || m_active); c++) begin
            sample();
            if (bus.gb_wen) wen_at.push_back(cyc);
            if (bus.gb_rstb) rstb_cnt++;
            advance();
        end
        chk("b2b_count", 64'(wen_at.size()), 64'(3));
        chk("b2b_rstb",  64'(rstb_cnt), 64'(0));
        for (int k = 1; k < wen_at.size(); k++)
            chk("b2b_spacing", 64'(wen_at[k] - wen_at[k-1]), 64'(3));

        // Reset asserted during the read wait cycle
        auto_new = 0; b2b = 0; wr_only = 0;
        sample();
        rq_left[0] = 1; t_valid[0] = 1; t_we[0] = 0; t_addr[0] = 24'hABCDE;
        advance();
        sample();
        chk("mr_rstb", 64'(bus.gb_rstb), 64'(1));
        advance();
        sample();
        chk("mr_wait_busy", 64'(busy), 64'(1));
        gb_rst = 1'b1;
        advance();
        sample();
        chk("mr_busy",    64'(busy), 64'(0));
        chk("mr_strobes", 64'({bus.gb_wen, bus.gb_rstb}), 64'(0));
        chk("mr_done",    64'(bus.req_done), 64'(0));
        chk("mr_gid",     64'(grant_id), 64'(0));
        // Pointer back at 0: with both pending, requester 0 must win first
        rq_left = '{1, 1};
        t_valid[0] = 1; t_we[0] = 1; t_valid[1] = 1; t_we[1] = 1;
        gb_rst = 1'b0;
        advance();
        sample();
        chk("mr_ptr_gid",  64'(grant_id), 64'(0));
        chk("mr_ptr_busy", 64'(busy), 64'(1));
        advance();
        drain("mr_drain", 50);

        // Random traffic
        auto_new = 1; b2b = 0; wr_only = 0; rd_fixed = 0;
        rq_left = '{25, 25};
        drain("rand_drain", 3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
